// File: rtl/dram_seq.sv
// DRAM cycle sequencer: 16-clock memory cycles alternating between a video/refresh slot
// and a CPU slot. It generates the multiplexed address and strobes, all registered.
module dram_seq #(
    parameter int REF_DIV = 32
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        cyc_start,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_ds,
    input  logic [19:0] cpu_addr,
    input  logic        video_req,
    input  logic [19:0] video_addr,
    output logic [9:0]  ram_a,
    output logic        ras_n,
    output logic [1:0]  cas_n,
    output logic        we_n,
    output logic        rd_latch,
    output logic        cpu_ack,
    output logic        video_ack,
    output logic        ref_busy
);

    typedef enum logic [1:0] {ACC_IDLE, ACC_CPU, ACC_VID, ACC_REF} acc_t;

    acc_t        acc, acc_n;
    logic [3:0]  phase, phase_n;
    logic        slot_vid, slot_vid_n;
    logic        ref_pend, ref_pend_n;
    logic [7:0]  ref_div, ref_div_n;
    logic [9:0]  ref_row, ref_row_n;
    logic [19:0] lat_addr, lat_addr_n;
    logic        lat_we, lat_we_n;
    logic [1:0]  lat_ds, lat_ds_n;
    logic        wrap;

    logic [9:0]  a_n;
    logic        ras_nx, we_nx, rd_nx, cack_nx, vack_nx, rb_nx;
    logic [1:0]  cas_nx;
    logic        ras_win, cas_win, we_win;

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            acc       <= ACC_IDLE;
            phase     <= 4'd0;
            slot_vid  <= 1'b1;
            ref_pend  <= 1'b0;
            ref_div   <= 8'd0;
            ref_row   <= 10'd0;
            lat_addr  <= 20'd0;
            lat_we    <= 1'b0;
            lat_ds    <= 2'b00;
            ram_a     <= 10'd0;
            ras_n     <= 1'b1;
            cas_n     <= 2'b11;
            we_n      <= 1'b1;
            rd_latch  <= 1'b0;
            cpu_ack   <= 1'b0;
            video_ack <= 1'b0;
            ref_busy  <= 1'b0;
        end else begin
            acc       <= acc_n;
            phase     <= phase_n;
            slot_vid  <= slot_vid_n;
            ref_pend  <= ref_pend_n;
            ref_div   <= ref_div_n;
            ref_row   <= ref_row_n;
            lat_addr  <= lat_addr_n;
            lat_we    <= lat_we_n;
            lat_ds    <= lat_ds_n;
            ram_a     <= a_n;
            ras_n     <= ras_nx;
            cas_n     <= cas_nx;
            we_n      <= we_nx;
            rd_latch  <= rd_nx;
            cpu_ack   <= cack_nx;
            video_ack <= vack_nx;
            ref_busy  <= rb_nx;
        end
    end

    // Next cycle state: the access is chosen only on the edge that samples cyc_start.
    always_comb begin
        acc_n      = acc;
        phase_n    = phase + 4'd1;
        slot_vid_n = slot_vid;
        ref_pend_n = ref_pend;
        ref_div_n  = ref_div;
        ref_row_n  = ref_row;
        lat_addr_n = lat_addr;
        lat_we_n   = lat_we;
        lat_ds_n   = lat_ds;
        wrap       = (ref_div == 8'(REF_DIV - 1));

        if (acc == ACC_REF && (cyc_start || phase == 4'd15))
            ref_row_n = ref_row + 10'd1;

        if (cyc_start) begin
            phase_n    = 4'd0;
            slot_vid_n = ~slot_vid;
            ref_div_n  = wrap ? 8'd0 : ref_div + 8'd1;
            ref_pend_n = ref_pend | wrap;
            if (slot_vid) begin
                if (ref_pend) begin
                    acc_n      = ACC_REF;
                    ref_pend_n = wrap;
                end else if (video_req) begin
                    acc_n      = ACC_VID;
                    lat_addr_n = video_addr;
                end else begin
                    acc_n = ACC_IDLE;
                end
            end else if (cpu_req) begin
                acc_n      = ACC_CPU;
                lat_addr_n = cpu_addr;
                lat_we_n   = cpu_we;
                lat_ds_n   = cpu_ds;
            end else begin
                acc_n = ACC_IDLE;
            end
        end else if (phase == 4'd15) begin
            acc_n = ACC_IDLE;
        end
    end

    // Output decode from the next phase/access so every output is a flop.
    always_comb begin
        a_n     = 10'd0;
        ras_nx  = 1'b1;
        cas_nx  = 2'b11;
        we_nx   = 1'b1;
        rd_nx   = 1'b0;
        cack_nx = 1'b0;
        vack_nx = 1'b0;
        rb_nx   = 1'b0;
        ras_win = (phase_n >= 4'd1) && (phase_n <= 4'd11);
        cas_win = (phase_n >= 4'd5) && (phase_n <= 4'd11);
        we_win  = (phase_n >= 4'd4) && (phase_n <= 4'd11);

        case (acc_n)
            ACC_CPU: begin
                a_n     = (phase_n < 4'd4) ? lat_addr_n[19:10] : lat_addr_n[9:0];
                ras_nx  = ~ras_win;
                cas_nx  = cas_win ? ~lat_ds_n : 2'b11;
                we_nx   = ~(lat_we_n && we_win);
                rd_nx   = ~lat_we_n && (phase_n == 4'd10);
                cack_nx = (phase_n == 4'd11);
            end
            ACC_VID: begin
                a_n     = (phase_n < 4'd4) ? lat_addr_n[19:10] : lat_addr_n[9:0];
                ras_nx  = ~ras_win;
                cas_nx  = cas_win ? 2'b00 : 2'b11;
                rd_nx   = (phase_n == 4'd10);
                vack_nx = (phase_n == 4'd10);
            end
            ACC_REF: begin
                a_n    = ref_row_n;
                ras_nx = ~ras_win;
                rb_nx  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_seq.sv
// Directed bench for dram_seq: per-phase vector table for whole cycles plus hand
// sequences for resync, mid-cycle reset and refresh (second instance, REF_DIV=4).
module tb_dram_seq;

    logic        clk32, resb, cyc_start, cpu_req, cpu_we, video_req;
    logic [1:0]  cpu_ds;
    logic [19:0] cpu_addr, video_addr;

    logic [9:0]  ram_a, ram_a4;
    logic        ras_n, we_n, rd_latch, cpu_ack, video_ack, ref_busy;
    logic        ras_n4, we_n4, rd_latch4, cpu_ack4, video_ack4, ref_busy4;
    logic [1:0]  cas_n, cas_n4;

    dram_seq dut (
        .clk32(clk32), .resb(resb), .cyc_start(cyc_start), .cpu_req(cpu_req),
        .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_addr(cpu_addr), .video_req(video_req),
        .video_addr(video_addr), .ram_a(ram_a), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .rd_latch(rd_latch), .cpu_ack(cpu_ack), .video_ack(video_ack),
        .ref_busy(ref_busy)
    );

    dram_seq #(.REF_DIV(4)) dut4 (
        .clk32(clk32), .resb(resb), .cyc_start(cyc_start), .cpu_req(cpu_req),
        .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_addr(cpu_addr), .video_req(video_req),
        .video_addr(video_addr), .ram_a(ram_a4), .ras_n(ras_n4), .cas_n(cas_n4),
        .we_n(we_n4), .rd_latch(rd_latch4), .cpu_ack(cpu_ack4), .video_ack(video_ack4),
        .ref_busy(ref_busy4)
    );

    typedef struct packed {
        logic [9:0] a;
        logic       ras;
        logic [1:0] cas;
        logic       we;
        logic       rd;
        logic       cack;
        logic       vack;
        logic       rb;
    } obs_t;

    typedef struct {
        int   sc;
        int   ph;
        obs_t exp;
    } vec_t;

    vec_t vq[$];
    obs_t obs0 [16];
    obs_t obs1 [16];
    int   errors = 0;
    int   checks = 0;
    int   n_cack = 0;
    int   n_vack = 0;

    localparam obs_t RST = '{a: 10'd0, ras: 1'b1, cas: 2'b11, we: 1'b1,
                             rd: 1'b0, cack: 1'b0, vack: 1'b0, rb: 1'b0};

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk32) begin
        if (cpu_ack)   n_cack <= n_cack + 1;
        if (video_ack) n_vack <= n_vack + 1;
    end

    function automatic obs_t cur0();
        return {ram_a, ras_n, cas_n, we_n, rd_latch, cpu_ack, video_ack, ref_busy};
    endfunction

    function automatic obs_t cur1();
        return {ram_a4, ras_n4, cas_n4, we_n4, rd_latch4, cpu_ack4, video_ack4, ref_busy4};
    endfunction

    function automatic obs_t mk(logic [9:0] a, logic ras, logic [1:0] cas, logic we,
                                logic rd, logic ca, logic va, logic rb);
        return {a, ras, cas, we, rd, ca, va, rb};
    endfunction

    task automatic add(int sc, int ph, obs_t e);
        vec_t v;
        v.sc = sc; v.ph = ph; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Starts at a negedge; pulses cyc_start and captures phases 0..15 (ends at phase 15).
    task automatic run_cycle();
        cyc_start = 1'b1;
        @(negedge clk32);
        cyc_start = 1'b0;
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk32);
            obs0[p] = cur0();
            obs1[p] = cur1();
        end
    endtask

    task automatic check_sc(int sc);
        foreach (vq[i])
            if (vq[i].sc == sc)
                chk($sformatf("sc%0d_ph%0d", sc, vq[i].ph), 32'(obs0[vq[i].ph]), 32'(vq[i].exp));
    endtask

    initial begin
        int bad, c0, v0;
        resb = 1'b0; cyc_start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_ds = 2'b00;
        cpu_addr = 20'd0; video_req = 1'b0; video_addr = 20'd0;

        // sc0 idle
        add(0, 0,  mk(10'h000, 1, 2'b11, 1, 0, 0, 0, 0));
        add(0, 6,  mk(10'h000, 1, 2'b11, 1, 0, 0, 0, 0));
        add(0, 10, mk(10'h000, 1, 2'b11, 1, 0, 0, 0, 0));
        // sc1 CPU read 0x12345, ds=11
        add(1, 0,  mk(10'h048, 1, 2'b11, 1, 0, 0, 0, 0));
        add(1, 1,  mk(10'h048, 0, 2'b11, 1, 0, 0, 0, 0));
        add(1, 3,  mk(10'h048, 0, 2'b11, 1, 0, 0, 0, 0));
        add(1, 4,  mk(10'h345, 0, 2'b11, 1, 0, 0, 0, 0));
        add(1, 5,  mk(10'h345, 0, 2'b00, 1, 0, 0, 0, 0));
        add(1, 10, mk(10'h345, 0, 2'b00, 1, 1, 0, 0, 0));
        add(1, 11, mk(10'h345, 0, 2'b00, 1, 0, 1, 0, 0));
        add(1, 12, mk(10'h345, 1, 2'b11, 1, 0, 0, 0, 0));
        add(1, 15, mk(10'h345, 1, 2'b11, 1, 0, 0, 0, 0));
        // sc2 video 0xABCDE
        add(2, 0,  mk(10'h2AF, 1, 2'b11, 1, 0, 0, 0, 0));
        add(2, 1,  mk(10'h2AF, 0, 2'b11, 1, 0, 0, 0, 0));
        add(2, 4,  mk(10'h0DE, 0, 2'b11, 1, 0, 0, 0, 0));
        add(2, 5,  mk(10'h0DE, 0, 2'b00, 1, 0, 0, 0, 0));
        add(2, 10, mk(10'h0DE, 0, 2'b00, 1, 1, 0, 1, 0));
        add(2, 11, mk(10'h0DE, 0, 2'b00, 1, 0, 0, 0, 0));
        add(2, 12, mk(10'h0DE, 1, 2'b11, 1, 0, 0, 0, 0));
        // sc3 CPU write 0x003FF, ds=01
        add(3, 0,  mk(10'h000, 1, 2'b11, 1, 0, 0, 0, 0));
        add(3, 3,  mk(10'h000, 0, 2'b11, 1, 0, 0, 0, 0));
        add(3, 4,  mk(10'h3FF, 0, 2'b11, 0, 0, 0, 0, 0));
        add(3, 5,  mk(10'h3FF, 0, 2'b10, 0, 0, 0, 0, 0));
        add(3, 10, mk(10'h3FF, 0, 2'b10, 0, 0, 0, 0, 0));
        add(3, 11, mk(10'h3FF, 0, 2'b10, 0, 0, 1, 0, 0));
        add(3, 12, mk(10'h3FF, 1, 2'b11, 1, 0, 0, 0, 0));
        // sc4 CPU read 0x00400, ds=00: no CAS, ack still given
        add(4, 0,  mk(10'h001, 1, 2'b11, 1, 0, 0, 0, 0));
        add(4, 5,  mk(10'h000, 0, 2'b11, 1, 0, 0, 0, 0));
        add(4, 10, mk(10'h000, 0, 2'b11, 1, 1, 0, 0, 0));
        add(4, 11, mk(10'h000, 0, 2'b11, 1, 0, 1, 0, 0));

        repeat (3) @(negedge clk32);
        chk("reset_vals", 32'(cur0()), 32'(RST));
        chk("reset_vals4", 32'(cur1()), 32'(RST));
        resb = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk32);
            if (cur0() !== RST || cur1() !== RST) bad++;
        end
        chk("unsynced_100clk", 32'(bad), 32'd0);

        // cycle 1 video slot (cpu_req ignored), cycle 2 CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_addr = 20'h12345;
        run_cycle(); check_sc(0);
        run_cycle(); check_sc(1);
        cpu_req = 1'b0; video_req = 1'b1; video_addr = 20'hABCDE;
        run_cycle(); check_sc(2);
        video_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_ds = 2'b01; cpu_addr = 20'h003FF;
        run_cycle(); check_sc(3);
        cpu_we = 1'b0; cpu_ds = 2'b00; cpu_addr = 20'h00400;
        run_cycle(); check_sc(0);
        run_cycle(); check_sc(4);

        // resync at phase 7 of a CPU read
        cpu_req = 1'b0;
        run_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_addr = 20'h12345;
        cyc_start = 1'b1;
        @(negedge clk32);
        cyc_start = 1'b0;
        repeat (7) @(negedge clk32);
        chk("resync_pre_strobes", 32'({ras_n, cas_n}), 32'b000);
        c0 = n_cack;
        cyc_start = 1'b1;
        @(negedge clk32);
        cyc_start = 1'b0;
        chk("resync_release", 32'({ras_n, cas_n, we_n}), 32'b1111);
        repeat (15) @(negedge clk32);
        chk("resync_no_ack", 32'(n_cack - c0), 32'd0);
        run_cycle(); check_sc(1);
        chk("resync_one_ack", 32'(n_cack - c0), 32'd1);

        // reset pulsed at phase 6 of a video access
        cpu_req = 1'b0; video_req = 1'b1; video_addr = 20'hABCDE;
        cyc_start = 1'b1;
        @(negedge clk32);
        cyc_start = 1'b0;
        repeat (6) @(negedge clk32);
        chk("vid_ph6_strobes", 32'({ras_n, cas_n}), 32'b000);
        v0 = n_vack;
        resb = 1'b0;
        #1;
        chk("rst_mid_release", 32'(cur0()), 32'(RST));
        @(negedge clk32);
        resb = 1'b1;
        repeat (20) @(negedge clk32);
        chk("rst_mid_no_ack", 32'(n_vack - v0), 32'd0);
        chk("rst_mid_idle", 32'(cur0()), 32'(RST));
        run_cycle(); check_sc(2);
        chk("rst_then_video", 32'(n_vack - v0), 32'd1);

        // refresh every 4th cycle on the REF_DIV=4 instance: cycles 5, 9, 13
        resb = 1'b0;
        @(negedge clk32);
        resb = 1'b1;
        video_req = 1'b1; cpu_req = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            run_cycle();
            if (c == 5 || c == 9 || c == 13) begin
                chk($sformatf("ref_c%0d_busy", c), 32'({obs1[0].rb, obs1[15].rb}), 32'b11);
                chk($sformatf("ref_c%0d_row", c), 32'(obs1[8].a), 32'((c - 5) / 4));
                chk($sformatf("ref_c%0d_strobes", c),
                    32'({obs1[7].ras, obs1[7].cas, obs1[7].we, obs1[10].vack}), 32'b01110);
            end else if (c % 2 == 1) begin
                chk($sformatf("ref_c%0d_video", c),
                    32'({obs1[10].vack, obs1[5].rb, obs1[7].cas}), 32'b1000);
            end else begin
                chk($sformatf("ref_c%0d_cpuidle", c), 32'({obs1[6].ras, obs1[6].rb}), 32'b10);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
